// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the generic pipeline stage registers.
package pipe_pkg;

   localparam logic [31:0] PC_START     = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_ENTRY = 32'h0000_4180;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One held pipeline entry {pc, data, valid}; clear picks the start or exception PC.
module pipe_slot #(
   parameter int unsigned DATA_W   = 32,
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] PC_EXC   = 32'h0000_4180
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              clear_pc_sel,
   input  logic              load,
   input  logic              drop,
   input  logic [31:0]       d_pc,
   input  logic [DATA_W-1:0] d_data,
   output logic [31:0]       q_pc,
   output logic [DATA_W-1:0] q_data,
   output logic              q_valid
);

   // Dropping keeps the PC but zeroes the payload so an empty slot reads as a NOP.
   always_ff @(posedge clk) begin
      if (clear) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_pc    <= clear_pc_sel ? PC_EXC : PC_RESET;
      end else if (load) begin
         q_valid <= 1'b1;
         q_pc    <= d_pc;
         q_data  <= d_data;
      end else if (drop) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and an optional second (skid) entry.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter logic [31:0] PC_RESET = PC_START,
   parameter logic [31:0] PC_EXC   = PC_EXC_ENTRY,
   parameter bit          SKID_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   stage_state_t      state, state_n;
   logic              in_fire, out_fire;
   logic              slot_clear, exc_sel;
   logic              main_load, main_from_skid, main_drop;
   logic              skid_load, skid_drop;
   logic [31:0]       main_pc, skid_pc;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              main_valid, skid_valid;

   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign slot_clear = !reset | flush;
   assign exc_sel    = reset;

   always_ff @(posedge clk) begin
      if (!reset || flush) state <= EMPTY;
      else                 state <= state_n;
   end

   always_comb begin
      state_n        = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_drop      = 1'b0;
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_n   = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (in_fire && SKID_EN) begin
               skid_load = 1'b1;
               state_n   = TWO;
            end else if (out_fire) begin
               main_drop = 1'b1;
               state_n   = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_drop      = 1'b1;
               state_n        = ONE;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   pipe_slot #(
      .DATA_W   (DATA_W),
      .PC_RESET (PC_RESET),
      .PC_EXC   (PC_EXC)
   ) u_main (
      .clk          (clk),
      .clear        (slot_clear),
      .clear_pc_sel (exc_sel),
      .load         (main_load),
      .drop         (main_drop),
      .d_pc         (main_from_skid ? skid_pc : in_pc),
      .d_data       (main_from_skid ? skid_data : in_data),
      .q_pc         (main_pc),
      .q_data       (main_data),
      .q_valid      (main_valid)
   );

   generate
      if (SKID_EN) begin : g_skid
         logic in_ready_q;

         pipe_slot #(
            .DATA_W   (DATA_W),
            .PC_RESET (PC_RESET),
            .PC_EXC   (PC_EXC)
         ) u_skid (
            .clk          (clk),
            .clear        (slot_clear),
            .clear_pc_sel (exc_sel),
            .load         (skid_load),
            .drop         (skid_drop),
            .d_pc         (in_pc),
            .d_data       (in_data),
            .q_pc         (skid_pc),
            .q_data       (skid_data),
            .q_valid      (skid_valid)
         );

         // Registered ready: a full stage refuses input without looking at out_ready.
         always_ff @(posedge clk) begin
            if (!reset || flush) in_ready_q <= 1'b1;
            else                 in_ready_q <= (state_n != TWO);
         end
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign skid_pc    = '0;
         assign skid_data  = '0;
         assign skid_valid = 1'b0;
         assign in_ready   = (state == EMPTY) | out_ready;
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_pc    = main_pc;
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid and non-skid stages, queue scoreboard with per-cycle order/hold monitors.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_pc, a_in_data, a_out_pc, a_out_data;
   logic [1:0]  a_occ;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_pc, b_in_data, b_out_pc, b_out_data;
   logic [1:0]  b_occ;

   logic [63:0] qa[$];
   logic [63:0] qb[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(32), .SKID_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_data(a_out_data),
      .occupancy(a_occ)
   );

   pipe_stage_skid #(.DATA_W(32), .SKID_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_data(b_out_data),
      .occupancy(b_occ)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one entry to dut_a, wait (bounded) for acceptance, then record it as expected.
   task automatic send_a(input logic [31:0] pc, input logic [31:0] data);
      bit ok = 1'b0;
      a_in_valid = 1'b1;
      a_in_pc    = pc;
      a_in_data  = data;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (ok) qa.push_back({pc, data});
      else    check("a_send_timeout", 64'd0, 64'd1);
   endtask

   // Monitor for dut_a: pops on every output transfer and checks hold stability.
   initial begin
      logic        hold;
      logic [63:0] hold_val, exp;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset || flush) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("a_hold_valid", a_out_valid, 1);
               check("a_hold_entry", {a_out_pc, a_out_data}, hold_val);
            end
            if (a_out_valid && a_out_ready) begin
               if (qa.size() == 0) check("a_unexpected_out", {a_out_pc, a_out_data}, 64'd0);
               else begin
                  exp = qa.pop_front();
                  check("a_order", {a_out_pc, a_out_data}, exp);
               end
            end
            hold     = a_out_valid & !a_out_ready;
            hold_val = {a_out_pc, a_out_data};
         end
      end
   end

   // Monitor for dut_b: same scoreboard plus the single-entry occupancy bound.
   initial begin
      logic        hold;
      logic [63:0] hold_val, exp;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset || flush) begin
            hold = 1'b0;
         end else begin
            check("b_occ_le1", (b_occ <= 2'd1), 1);
            if (hold) begin
               check("b_hold_valid", b_out_valid, 1);
               check("b_hold_entry", {b_out_pc, b_out_data}, hold_val);
            end
            if (b_out_valid && b_out_ready) begin
               if (qb.size() == 0) check("b_unexpected_out", {b_out_pc, b_out_data}, 64'd0);
               else begin
                  exp = qb.pop_front();
                  check("b_order", {b_out_pc, b_out_data}, exp);
               end
            end
            hold     = b_out_valid & !b_out_ready;
            hold_val = {b_out_pc, b_out_data};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        t6_rdy[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] t6_pc[6]   = '{32'h3000, 32'h3004, 32'h3004, 32'h3008, 32'h3008, 32'h300C};
      logic        t6_push[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        t6_irdy[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  t6_occ[6]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

      reset = 1'b0; flush = 1'b0;
      a_in_valid = 1'b0; a_in_pc = '0; a_in_data = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_pc = '0; b_in_data = '0; b_out_ready = 1'b0;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      check("t1_a_valid", a_out_valid, 0);
      check("t1_a_pc", a_out_pc, 32'h3000);
      check("t1_a_data", a_out_data, 0);
      check("t1_a_in_ready", a_in_ready, 1);
      check("t1_a_occ", a_occ, 0);
      check("t1_b_pc", b_out_pc, 32'h3000);
      check("t1_b_in_ready", b_in_ready, 1);
      reset = 1'b1;

      // 2: streaming at full rate
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_a(32'h3000 + 32'(4 * i), 32'h1000_0001 + 32'(i));
         check("t2_pc", a_out_pc, 32'h3000 + 32'(4 * i));
         check("t2_occ", a_occ, 1);
         check("t2_in_ready", a_in_ready, 1);
      end
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      check("t2_empty_valid", a_out_valid, 0);
      check("t2_empty_bubble", a_out_data, 0);
      check("t2_empty_pc_held", a_out_pc, 32'h3008);
      check("t2_empty_occ", a_occ, 0);

      // 3: fill the skid, refuse a third entry, then drain in order
      a_out_ready = 1'b0;
      send_a(32'h3000, 32'hAAAA_0000);
      check("t3_occ1", a_occ, 1);
      send_a(32'h3004, 32'hBBBB_0000);
      check("t3_occ2", a_occ, 2);
      check("t3_full_in_ready", a_in_ready, 0);
      a_in_pc = 32'h3008; a_in_data = 32'hCCCC_0000;
      @(posedge clk); #1;
      check("t3_c_refused_occ", a_occ, 2);
      check("t3_c_refused_rdy", a_in_ready, 0);
      check("t3_head_is_a", a_out_pc, 32'h3000);
      a_out_ready = 1'b1;
      send_a(32'h3008, 32'hCCCC_0000);
      a_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t3_drained_occ", a_occ, 0);
      check("t3_queue_empty", qa.size(), 0);

      // 4: flush from TWO with a concurrent input offer
      a_out_ready = 1'b0;
      send_a(32'h3010, 32'h0000_0010);
      send_a(32'h3014, 32'h0000_0014);
      check("t4_occ2", a_occ, 2);
      a_in_valid = 1'b1; a_in_pc = 32'h3018; a_in_data = 32'h0000_0018;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; a_in_valid = 1'b0;
      qa.delete(); qb.delete();
      check("t4_valid", a_out_valid, 0);
      check("t4_pc", a_out_pc, 32'h4180);
      check("t4_data", a_out_data, 0);
      check("t4_occ", a_occ, 0);
      check("t4_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      check("t4_input_dropped", a_occ, 0);

      // 5: reset wins over flush
      send_a(32'h3020, 32'h0000_0020);
      a_in_valid = 1'b0;
      flush = 1'b1; reset = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0; reset = 1'b1;
      qa.delete(); qb.delete();
      check("t5_pc", a_out_pc, 32'h3000);
      check("t5_occ", a_occ, 0);
      check("t5_valid", a_out_valid, 0);

      // 6: single-entry stage with out_ready toggling
      for (int i = 0; i < 6; i++) begin
         b_in_valid  = 1'b1;
         b_out_ready = t6_rdy[i];
         b_in_pc     = t6_pc[i];
         b_in_data   = ~t6_pc[i];
         if (t6_push[i]) qb.push_back({t6_pc[i], ~t6_pc[i]});
         @(negedge clk);
         check("t6_in_ready", b_in_ready, t6_irdy[i]);
         check("t6_occ", b_occ, t6_occ[i]);
         @(posedge clk); #1;
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t6_drained_occ", b_occ, 0);
      check("t6_queue_empty", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
